// File: rtl/mem_log_pkg.sv
// mem_log_pkg: shared state encoding, mode constants and pre-trigger clamp for the capture logger
package mem_log_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_FULL  = 3'd4,
    S_READ  = 3'd5
  } state_t;
  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_PRETRIG = 1'b1;
  function automatic logic [31:0] clamp_pre(input logic [31:0] v, input logic [31:0] depth);
    return v >= depth ? depth - 32'd1 : v;
  endfunction
endpackage

// File: rtl/mem_log_if.sv
// mem_log_if: control, sample and read-out signals of the capture logger
interface mem_log_if #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int NB_CH           = 4,
  parameter int DECIM_WIDTH     = 8,
  parameter int CW              = NB_CH > 1 ? $clog2(NB_CH) : 1
);
  logic                             i_valid;
  logic [NB_CH*BRAM_DATA_WIDTH-1:0] i_filter_data;
  logic                             i_run_log;
  logic                             i_mode;
  logic                             i_trig;
  logic [BRAM_ADDR_WIDTH-1:0]       i_pretrig_len;
  logic [DECIM_WIDTH-1:0]           i_decim;
  logic                             i_read_log;
  logic [BRAM_ADDR_WIDTH-1:0]       i_addr_log_to_mem;
  logic [CW-1:0]                    i_ch_sel;
  logic                             o_mem_full;
  logic                             o_busy;
  logic                             o_trig_seen;
  logic [BRAM_DATA_WIDTH-1:0]       o_data_log_from_mem;
  modport master (
    output i_valid, i_filter_data, i_run_log, i_mode, i_trig, i_pretrig_len, i_decim,
           i_read_log, i_addr_log_to_mem, i_ch_sel,
    input  o_mem_full, o_busy, o_trig_seen, o_data_log_from_mem
  );
  modport slave (
    input  i_valid, i_filter_data, i_run_log, i_mode, i_trig, i_pretrig_len, i_decim,
           i_read_log, i_addr_log_to_mem, i_ch_sel,
    output o_mem_full, o_busy, o_trig_seen, o_data_log_from_mem
  );
endinterface

// File: rtl/mem_log_bram.sv
// mem_log_bram: simple dual-port block RAM, write port A, registered read port B
module mem_log_bram #(
  parameter int AW = 15,
  parameter int W  = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  // write on port A, registered read on port B; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_log_trig.sv
// mem_log_trig: multi-channel triggered capture logger with decimation and rotated read-out
module mem_log_trig
  import mem_log_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int NB_CH           = 4,
  parameter int DECIM_WIDTH     = 8
) (
  input logic     clk,
  input logic     i_rst,
  mem_log_if.slave bus
);
  localparam int AW    = BRAM_ADDR_WIDTH;
  localparam int DW    = BRAM_DATA_WIDTH;
  localparam int W     = NB_CH * DW;
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = NB_CH > 1 ? $clog2(NB_CH) : 1;
  state_t                 state_q, state_d;
  logic [AW-1:0]          waddr_q, waddr_d, off_q, off_d, pre_q, pre_d;
  logic [AW:0]            cnt_q, cnt_d, post_q, post_d, tgt;
  logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d, decim_q, decim_d;
  logic                   seen_q, seen_d, rd_q, rd_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic                   cap, store, accept, rd_en, we;
  logic [AW-1:0]          raddr;
  logic [W-1:0]           rdata;
  // next-state, counters, trigger acceptance and read-port control
  always_comb begin
    cap     = state_q inside {S_RUN, S_ARMED, S_POST};
    store   = cap && bus.i_valid && dcnt_q == '0;
    we      = store && !bus.i_run_log;
    tgt     = (AW+1)'(DEPTH) - {1'b0, pre_q};
    accept  = state_q == S_ARMED && bus.i_trig && cnt_q >= {1'b0, pre_q};
    rd_en   = state_q inside {S_FULL, S_READ};
    raddr   = bus.i_addr_log_to_mem + off_q;
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    dcnt_d  = dcnt_q;
    decim_d = decim_q;
    seen_d  = seen_q;
    rd_d    = rd_q;
    ch_d    = ch_q;
    if (cap && bus.i_valid) dcnt_d = dcnt_q == decim_q ? '0 : dcnt_q + 1'b1;
    if (store) begin
      waddr_d = waddr_q + 1'b1;
      cnt_d   = cnt_q == (AW+1)'(DEPTH) ? cnt_q : cnt_q + 1'b1;
    end
    case (state_q)
      S_RUN: if (store && cnt_q == (AW+1)'(DEPTH - 1)) state_d = S_FULL;
      S_ARMED:
        if (accept) begin
          seen_d  = 1'b1;
          off_d   = waddr_q - pre_q;
          post_d  = store ? (AW+1)'(1) : '0;
          state_d = store && tgt == (AW+1)'(1) ? S_FULL : S_POST;
        end
      S_POST:
        if (store) begin
          post_d  = post_q + 1'b1;
          state_d = post_q + 1'b1 == tgt ? S_FULL : S_POST;
        end
      S_FULL: if (bus.i_read_log) state_d = S_READ;
      default: ;
    endcase
    if (rd_en) begin
      rd_d = 1'b1;
      ch_d = bus.i_ch_sel;
    end
    if (bus.i_run_log) begin
      state_d = bus.i_mode == MODE_PRETRIG ? S_ARMED : S_RUN;
      waddr_d = '0;
      off_d   = '0;
      cnt_d   = '0;
      post_d  = '0;
      dcnt_d  = '0;
      seen_d  = 1'b0;
      decim_d = bus.i_decim;
      pre_d   = AW'(clamp_pre(32'(bus.i_pretrig_len), 32'(DEPTH)));
    end
  end
  // state and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      post_q  <= '0;
      dcnt_q  <= '0;
      decim_q <= '0;
      seen_q  <= 1'b0;
      rd_q    <= 1'b0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      dcnt_q  <= dcnt_d;
      decim_q <= decim_d;
      seen_q  <= seen_d;
      rd_q    <= rd_d;
      ch_q    <= ch_d;
    end
  end
  mem_log_bram #(.AW(AW), .W(W)) u_bram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr_q),
    .wdata(bus.i_filter_data),
    .re   (rd_en),
    .raddr(raddr),
    .rdata(rdata)
  );
  assign bus.o_busy              = cap;
  assign bus.o_mem_full          = rd_en;
  assign bus.o_trig_seen         = seen_q;
  assign bus.o_data_log_from_mem = rd_q ? rdata[int'(ch_q)*DW +: DW] : '0;
endmodule

// File: tb/tb_mem_log_trig.sv
// tb_mem_log_trig: directed self-checking bench for the capture logger
module tb_mem_log_trig;
  logic clk, rst;
  int checks = 0;
  int failures = 0;
  mem_log_if #(.BRAM_ADDR_WIDTH(4), .BRAM_DATA_WIDTH(16), .NB_CH(4), .DECIM_WIDTH(8)) bus ();
  mem_log_trig #(.BRAM_ADDR_WIDTH(4), .BRAM_DATA_WIDTH(16), .NB_CH(4), .DECIM_WIDTH(8)) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] smp(input int k, input int c);
    return 16'((c << 12) | k);
  endfunction
  function automatic logic [63:0] word(input int k);
    logic [63:0] w;
    for (int c = 0; c < 4; c++) w[c*16 +: 16] = smp(k, c);
    return w;
  endfunction
  task automatic start(input logic m, input int pre, input int dec);
    bus.i_run_log = 1'b1;
    bus.i_mode = m;
    bus.i_pretrig_len = 4'(pre);
    bus.i_decim = 8'(dec);
    @(negedge clk);
    bus.i_run_log = 1'b0;
  endtask
  task automatic send(input int k, input logic t);
    bus.i_valid = 1'b1;
    bus.i_filter_data = word(k);
    bus.i_trig = t;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_trig = 1'b0;
  endtask
  task automatic rd(input int a, input int c, output logic [15:0] d);
    bus.i_addr_log_to_mem = 4'(a);
    bus.i_ch_sel = 2'(c);
    @(negedge clk);
    d = bus.o_data_log_from_mem;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.o_mem_full); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_trig_seen !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", bus.o_trig_seen); end
    checks++; if (bus.o_data_log_from_mem !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.o_data_log_from_mem); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_fill;
    logic [15:0] d;
    start(1'b0, 0, 0);
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL fill_busy got=%b exp=1", bus.o_busy); end
    for (int k = 0; k < 15; k++) send(k, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL fill_early_full got=%b exp=0", bus.o_mem_full); end
    send(15, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.o_mem_full); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL fill_busy_done got=%b exp=0", bus.o_busy); end
    bus.i_read_log = 1'b1;
    @(negedge clk);
    bus.i_read_log = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rd(k, k % 4, d);
      checks++; if (d !== smp(k, k % 4)) begin failures++; $display("FAIL fill_rd a=%0d got=%h exp=%h", k, d, smp(k, k % 4)); end
    end
    for (int c = 0; c < 4; c++) begin
      rd(9, c, d);
      checks++; if (d !== smp(9, c)) begin failures++; $display("FAIL fill_ch c=%0d got=%h exp=%h", c, d, smp(9, c)); end
    end
    checks++; if (bus.o_mem_full !== 1'b1) begin failures++; $display("FAIL read_full got=%b exp=1", bus.o_mem_full); end
  endtask
  task automatic test_decim;
    logic [15:0] d;
    start(1'b0, 0, 2);
    for (int k = 0; k < 45; k++) send(k, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL decim_early_full got=%b exp=0", bus.o_mem_full); end
    send(45, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b1) begin failures++; $display("FAIL decim_full got=%b exp=1", bus.o_mem_full); end
    for (int k = 0; k < 16; k++) begin
      rd(k, k % 4, d);
      checks++; if (d !== smp(3 * k, k % 4)) begin failures++; $display("FAIL decim_rd a=%0d got=%h exp=%h", k, d, smp(3 * k, k % 4)); end
    end
  endtask
  task automatic test_pretrig;
    logic [15:0] d;
    start(1'b1, 4, 0);
    for (int k = 0; k < 20; k++) send(k, 1'b0);
    checks++; if (bus.o_trig_seen !== 1'b0) begin failures++; $display("FAIL pre_trig_early got=%b exp=0", bus.o_trig_seen); end
    send(20, 1'b1);
    checks++; if (bus.o_trig_seen !== 1'b1) begin failures++; $display("FAIL pre_trig_seen got=%b exp=1", bus.o_trig_seen); end
    for (int k = 21; k < 31; k++) send(k, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL pre_early_full got=%b exp=0", bus.o_mem_full); end
    send(31, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b1) begin failures++; $display("FAIL pre_full got=%b exp=1", bus.o_mem_full); end
    for (int k = 0; k < 16; k++) begin
      rd(k, k % 4, d);
      checks++; if (d !== smp(16 + k, k % 4)) begin failures++; $display("FAIL pre_rd a=%0d got=%h exp=%h", k, d, smp(16 + k, k % 4)); end
    end
  endtask
  task automatic test_early_trig;
    logic [15:0] d;
    int la[4] = '{0, 4, 13, 15};
    int ex[4] = '{2, 6, 15, 17};
    start(1'b1, 4, 0);
    send(0, 1'b0);
    send(1, 1'b0);
    bus.i_trig = 1'b1;
    @(negedge clk);
    bus.i_trig = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_trig_seen !== 1'b0) begin failures++; $display("FAIL early_trig_ignored got=%b exp=0", bus.o_trig_seen); end
    for (int k = 2; k < 6; k++) send(k, 1'b0);
    bus.i_trig = 1'b1;
    @(negedge clk);
    bus.i_trig = 1'b0;
    checks++; if (bus.o_trig_seen !== 1'b1) begin failures++; $display("FAIL late_trig_seen got=%b exp=1", bus.o_trig_seen); end
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL late_trig_busy got=%b exp=1", bus.o_busy); end
    for (int k = 6; k < 17; k++) send(k, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL late_early_full got=%b exp=0", bus.o_mem_full); end
    send(17, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b1) begin failures++; $display("FAIL late_full got=%b exp=1", bus.o_mem_full); end
    for (int i = 0; i < 4; i++) begin
      rd(la[i], 1, d);
      checks++; if (d !== smp(ex[i], 1)) begin failures++; $display("FAIL late_rd a=%0d got=%h exp=%h", la[i], d, smp(ex[i], 1)); end
    end
  endtask
  task automatic test_rst_mid;
    logic [15:0] d;
    start(1'b1, 4, 0);
    for (int k = 0; k < 6; k++) send(k, 1'b0);
    send(6, 1'b1);
    send(7, 1'b0);
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_trig_seen !== 1'b0) begin failures++; $display("FAIL rst_trig got=%b exp=0", bus.o_trig_seen); end
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus.o_mem_full); end
    checks++; if (bus.o_data_log_from_mem !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", bus.o_data_log_from_mem); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(1'b0, 0, 0);
    for (int k = 0; k < 16; k++) send(64 + k, 1'b0);
    checks++; if (bus.o_mem_full !== 1'b1) begin failures++; $display("FAIL rst_refill_full got=%b exp=1", bus.o_mem_full); end
    rd(5, 1, d);
    checks++; if (d !== smp(69, 1)) begin failures++; $display("FAIL rst_refill_rd got=%h exp=%h", d, smp(69, 1)); end
    rd(15, 3, d);
    checks++; if (d !== smp(79, 3)) begin failures++; $display("FAIL rst_refill_rd2 got=%h exp=%h", d, smp(79, 3)); end
  endtask
  task automatic test_back_to_back;
    bus.i_run_log = 1'b1;
    bus.i_read_log = 1'b1;
    bus.i_mode = 1'b0;
    bus.i_decim = 8'd0;
    @(negedge clk);
    bus.i_run_log = 1'b0;
    bus.i_read_log = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", bus.o_busy); end
    checks++; if (bus.o_mem_full !== 1'b0) begin failures++; $display("FAIL restart_full got=%b exp=0", bus.o_mem_full); end
  endtask
  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_filter_data = '0;
    bus.i_run_log = 1'b0;
    bus.i_mode = 1'b0;
    bus.i_trig = 1'b0;
    bus.i_pretrig_len = '0;
    bus.i_decim = '0;
    bus.i_read_log = 1'b0;
    bus.i_addr_log_to_mem = '0;
    bus.i_ch_sel = '0;
    test_reset;
    test_fill;
    test_decim;
    test_pretrig;
    test_early_trig;
    test_rst_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
